// File: rtl/sip_hit_decoder.sv
// Serial hit-packet deserialiser, raw-packet FIFO and sequential LFSR decoder.
// A 28-bit frame (MSB first) is captured after a valid_out strobe, queued, and
// its TOA/FTOA/ToT LFSR codes are converted to binary step counts by walking
// three LFSRs from their all-ones seed until each one matches its code.
module sip_hit_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_40MHz,
    input  logic       rst_n,
    input  logic       valid_out,
    input  logic       route_data_proc,
    input  logic       hit_ready,
    output logic       hit_valid,
    output logic [8:0] hit_toa,
    output logic [4:0] hit_ftoa,
    output logic [7:0] hit_tot,
    output logic       hit_flag,
    output logic [2:0] hit_addr,
    output logic [1:0] hit_tag,
    output logic [2:0] hit_err,
    output logic [7:0] overflow_cnt,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_OUT} state_t;

    function automatic logic [8:0] toa_step(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction
    function automatic logic [4:0] ftoa_step(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction
    function automatic logic [7:0] tot_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // capture state
    logic        cap_active_q, cap_active_d;
    logic [4:0]  cap_idx_q, cap_idx_d;
    logic [26:0] sr_q, sr_d;
    logic        wr_pend_q, wr_pend_d;
    logic [27:0] wr_data_q, wr_data_d;

    // fifo state
    logic [27:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  ovf_q, ovf_d;
    logic        fifo_empty, fifo_full, push, pop;
    logic [27:0] rd_data;

    // decoder state
    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [8:0]  toa_lfsr_q, toa_lfsr_d;
    logic [4:0]  ftoa_lfsr_q, ftoa_lfsr_d;
    logic [7:0]  tot_lfsr_q, tot_lfsr_d;
    logic [27:0] pkt_q, pkt_d;
    logic [2:0]  res_q, res_d, res_n;
    logic [2:0]  err_q, err_d;
    logic [8:0]  toa_val_q, toa_val_d;
    logic [4:0]  ftoa_val_q, ftoa_val_d;
    logic [7:0]  tot_val_q, tot_val_d;
    logic        hit_valid_q, hit_valid_d;

    // Frame capture: the strobe cycle supplies bit27, the next 27 cycles bits 26..0.
    always_comb begin
        cap_active_d = cap_active_q;
        cap_idx_d    = cap_idx_q;
        sr_d         = sr_q;
        wr_pend_d    = 1'b0;
        wr_data_d    = wr_data_q;
        if (!cap_active_q) begin
            if (valid_out) begin
                cap_active_d = 1'b1;
                cap_idx_d    = 5'd26;
                sr_d         = {26'd0, route_data_proc};
            end
        end else begin
            sr_d = {sr_q[25:0], route_data_proc};
            if (cap_idx_q == 5'd0) begin
                cap_active_d = 1'b0;
                wr_pend_d    = 1'b1;
                wr_data_d    = {sr_q, route_data_proc};
            end else begin
                cap_idx_d = cap_idx_q - 5'd1;
            end
        end
    end

    // FIFO pointers and drop counter; a pop frees the slot for a same-cycle write.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_data    = fifo_mem[rd_ptr_q[AW-1:0]];
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        push       = wr_pend_q && (!fifo_full || pop);
        wr_ptr_d   = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
        ovf_d      = ovf_q;
        if (wr_pend_q && !push && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // Decoder: load seeds on pop, step unresolved LFSRs until all codes match.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        toa_lfsr_d  = toa_lfsr_q;
        ftoa_lfsr_d = ftoa_lfsr_q;
        tot_lfsr_d  = tot_lfsr_q;
        pkt_d       = pkt_q;
        res_d       = res_q;
        res_n       = res_q;
        err_d       = err_q;
        toa_val_d   = toa_val_q;
        ftoa_val_d  = ftoa_val_q;
        tot_val_d   = tot_val_q;
        hit_valid_d = hit_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pkt_d       = rd_data;
                    toa_lfsr_d  = '1;
                    ftoa_lfsr_d = '1;
                    tot_lfsr_d  = '1;
                    cnt_d       = 9'd0;
                    // an all-zero code can never be reached, so settle it now
                    res_d       = {rd_data[27:19] == 9'd0, rd_data[18:14] == 5'd0,
                                   rd_data[13:6] == 8'd0};
                    err_d       = res_d;
                    toa_val_d   = res_d[2] ? 9'h1FF : 9'd0;
                    ftoa_val_d  = res_d[1] ? 5'h1F : 5'd0;
                    tot_val_d   = res_d[0] ? 8'hFF : 8'd0;
                    state_d     = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (!res_q[2]) begin
                    if (toa_lfsr_q == pkt_q[27:19]) begin
                        res_n[2]  = 1'b1;
                        toa_val_d = cnt_q;
                    end else begin
                        toa_lfsr_d = toa_step(toa_lfsr_q);
                    end
                end
                if (!res_q[1]) begin
                    if (ftoa_lfsr_q == pkt_q[18:14]) begin
                        res_n[1]   = 1'b1;
                        ftoa_val_d = cnt_q[4:0];
                    end else begin
                        ftoa_lfsr_d = ftoa_step(ftoa_lfsr_q);
                    end
                end
                if (!res_q[0]) begin
                    if (tot_lfsr_q == pkt_q[13:6]) begin
                        res_n[0]  = 1'b1;
                        tot_val_d = cnt_q[7:0];
                    end else begin
                        tot_lfsr_d = tot_step(tot_lfsr_q);
                    end
                end
                res_d = res_n;
                cnt_d = cnt_q + 9'd1;
                if (&res_n) begin
                    state_d     = ST_OUT;
                    hit_valid_d = 1'b1;
                end else if (cnt_q == 9'd510) begin
                    // guard against a code the walk can never hit
                    if (!res_n[2]) begin err_d[2] = 1'b1; toa_val_d  = 9'h1FF; end
                    if (!res_n[1]) begin err_d[1] = 1'b1; ftoa_val_d = 5'h1F;  end
                    if (!res_n[0]) begin err_d[0] = 1'b1; tot_val_d  = 8'hFF;  end
                    res_d       = 3'b111;
                    state_d     = ST_OUT;
                    hit_valid_d = 1'b1;
                end
            end
            ST_OUT: begin
                if (hit_ready) begin
                    hit_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register capture, FIFO pointer and decoder state with synchronous reset.
    always_ff @(posedge clk_40MHz) begin
        if (!rst_n) begin
            cap_active_q <= 1'b0;
            cap_idx_q    <= 5'd0;
            sr_q         <= '0;
            wr_pend_q    <= 1'b0;
            wr_data_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 8'd0;
            state_q      <= ST_IDLE;
            cnt_q        <= 9'd0;
            toa_lfsr_q   <= '0;
            ftoa_lfsr_q  <= '0;
            tot_lfsr_q   <= '0;
            pkt_q        <= '0;
            res_q        <= 3'd0;
            err_q        <= 3'd0;
            toa_val_q    <= '0;
            ftoa_val_q   <= '0;
            tot_val_q    <= '0;
            hit_valid_q  <= 1'b0;
        end else begin
            cap_active_q <= cap_active_d;
            cap_idx_q    <= cap_idx_d;
            sr_q         <= sr_d;
            wr_pend_q    <= wr_pend_d;
            wr_data_q    <= wr_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            toa_lfsr_q   <= toa_lfsr_d;
            ftoa_lfsr_q  <= ftoa_lfsr_d;
            tot_lfsr_q   <= tot_lfsr_d;
            pkt_q        <= pkt_d;
            res_q        <= res_d;
            err_q        <= err_d;
            toa_val_q    <= toa_val_d;
            ftoa_val_q   <= ftoa_val_d;
            tot_val_q    <= tot_val_d;
            hit_valid_q  <= hit_valid_d;
        end
    end

    // Packet storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_40MHz) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= wr_data_q;
        end
    end

    assign hit_valid    = hit_valid_q;
    assign hit_toa      = toa_val_q;
    assign hit_ftoa     = ftoa_val_q;
    assign hit_tot      = tot_val_q;
    assign hit_flag     = pkt_q[5];
    assign hit_addr     = pkt_q[4:2];
    assign hit_tag      = pkt_q[1:0];
    assign hit_err      = err_q;
    assign overflow_cnt = ovf_q;
    assign busy         = cap_active_q | wr_pend_q | (state_q != ST_IDLE) | !fifo_empty;
endmodule
